// File: rtl/sched_pkg.sv
// Shared types and constants for the stereo sample scheduler.
package sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSendL,
        StSendR,
        StWait,
        StOut
    } sched_state_t;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    // Unsigned code that represents silence for a sample of the given width.
    function automatic logic [31:0] midscale(input int unsigned size);
        return 32'd1 << (size - 1);
    endfunction

endpackage

// File: rtl/stereo_sample_scheduler_if.sv
// ADC, effect-chain and DAC signals of the stereo sample scheduler.
interface stereo_sample_scheduler_if #(
    parameter int unsigned size = 16
);
    logic            adc_vld;
    logic [size-1:0] adc_l;
    logic [size-1:0] adc_r;
    logic            adc_rdy;

    logic            fx_in_vld;
    logic [size-1:0] fx_in;
    logic            fx_in_ch;
    logic            fx_in_rdy;

    logic            fx_out_vld;
    logic [size-1:0] fx_out;
    logic            fx_out_ch;

    logic            dac_vld;
    logic [size-1:0] dac_l;
    logic [size-1:0] dac_r;
    logic            err_timeout;

    // Scheduler side.
    modport master (
        input  adc_vld, adc_l, adc_r, fx_in_rdy, fx_out_vld, fx_out, fx_out_ch,
        output adc_rdy, fx_in_vld, fx_in, fx_in_ch, dac_vld, dac_l, dac_r, err_timeout
    );

    // Converter / effect chain / DAC side.
    modport slave (
        output adc_vld, adc_l, adc_r, fx_in_rdy, fx_out_vld, fx_out, fx_out_ch,
        input  adc_rdy, fx_in_vld, fx_in, fx_in_ch, dac_vld, dac_l, dac_r, err_timeout
    );
endinterface

// File: rtl/sign2unsign.sv
// Two's complement to offset-binary: add midscale, i.e. flip the MSB.
module sign2unsign #(
    parameter int unsigned size = 16
) (
    input  logic [size-1:0] din,
    output logic [size-1:0] dout
);
    localparam logic [size-1:0] Msb = {1'b1, {(size - 1){1'b0}}};

    assign dout = din ^ Msb;
endmodule

// File: rtl/unsign2sign.sv
// Offset-binary to two's complement: subtract midscale, i.e. flip the MSB.
module unsign2sign #(
    parameter int unsigned size = 16
) (
    input  logic [size-1:0] din,
    output logic [size-1:0] dout
);
    localparam logic [size-1:0] Msb = {1'b1, {(size - 1){1'b0}}};

    assign dout = din ^ Msb;
endmodule

// File: rtl/stereo_sample_scheduler.sv
// Time-shares one mono effect chain between L and R, reassembling tagged results into a
// registered stereo DAC frame; a watchdog fills missing results with silence.
module stereo_sample_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned size       = 16,
    parameter int unsigned FX_TIMEOUT = 64
) (
    input logic                      clk,
    input logic                      rst,
    stereo_sample_scheduler_if.master bus
);

    localparam int unsigned      CntW    = $clog2(FX_TIMEOUT);
    localparam logic [CntW-1:0]  CntMax  = CntW'(FX_TIMEOUT - 1);
    localparam logic [size-1:0]  Silence = size'(midscale(size));

    sched_state_t    state_q, state_d;
    logic [size-1:0] lat_l_q, lat_r_q;
    logic [size-1:0] res_l_q, res_l_d, res_r_q, res_r_d;
    logic [size-1:0] dac_l_q, dac_l_d, dac_r_q, dac_r_d;
    logic [size-1:0] fx_mux, fx_signed, res_l_u, res_r_u;
    logic            got_l_q, got_l_d, got_r_q, got_r_d;
    logic            to_q, to_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept, capture, cap_l, cap_r, got_both, timeout_hit;

    assign accept      = (state_q == StIdle) && bus.adc_vld;
    assign capture     = bus.fx_out_vld && ((state_q == StSendR) || (state_q == StWait));
    assign cap_l       = capture && (bus.fx_out_ch == CH_L);
    assign cap_r       = capture && (bus.fx_out_ch == CH_R);
    assign got_both    = (got_l_q || cap_l) && (got_r_q || cap_r);
    assign timeout_hit = (state_q == StWait) && !got_both && (cnt_q == CntMax);

    assign fx_mux = (state_q == StSendR) ? lat_r_q : lat_l_q;

    unsign2sign #(.size(size)) u_u2s (.din(fx_mux), .dout(fx_signed));
    sign2unsign #(.size(size)) u_s2u_l (.din(res_l_d), .dout(res_l_u));
    sign2unsign #(.size(size)) u_s2u_r (.din(res_r_d), .dout(res_r_u));

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.adc_vld)   state_d = StSendL;
            StSendL: if (bus.fx_in_rdy) state_d = StSendR;
            StSendR: if (bus.fx_in_rdy) state_d = StWait;
            StWait:  if (got_both || timeout_hit) state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.adc_rdy     = (state_q == StIdle);
        bus.fx_in_vld   = (state_q == StSendL) || (state_q == StSendR);
        bus.fx_in_ch    = (state_q == StSendR) ? CH_R : CH_L;
        bus.fx_in       = bus.fx_in_vld ? fx_signed : '0;
        bus.dac_vld     = (state_q == StOut);
        bus.err_timeout = (state_q == StOut) && to_q;
        bus.dac_l       = dac_l_q;
        bus.dac_r       = dac_r_q;
    end

    always_comb begin
        res_l_d = res_l_q;
        res_r_d = res_r_q;
        got_l_d = got_l_q;
        got_r_d = got_r_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        if (accept) begin
            got_l_d = 1'b0;
            got_r_d = 1'b0;
            to_d    = 1'b0;
        end
        // Last result per tag wins.
        if (cap_l) begin
            res_l_d = bus.fx_out;
            got_l_d = 1'b1;
        end
        if (cap_r) begin
            res_r_d = bus.fx_out;
            got_r_d = 1'b1;
        end
        if ((state_q == StSendR) && bus.fx_in_rdy) cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
            if (timeout_hit) begin
                to_d = 1'b1;
                if (!got_l_d) res_l_d = '0;
                if (!got_r_d) res_r_d = '0;
            end
        end
    end

    // Kept apart from the block above so the converters do not form a combinational loop.
    always_comb begin
        dac_l_d = dac_l_q;
        dac_r_d = dac_r_q;
        if ((state_q == StWait) && (state_d == StOut)) begin
            dac_l_d = res_l_u;
            dac_r_d = res_r_u;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_l_q <= '0;
            lat_r_q <= '0;
            res_l_q <= '0;
            res_r_q <= '0;
            got_l_q <= 1'b0;
            got_r_q <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            dac_l_q <= Silence;
            dac_r_q <= Silence;
        end else begin
            if (accept) begin
                lat_l_q <= bus.adc_l;
                lat_r_q <= bus.adc_r;
            end
            res_l_q <= res_l_d;
            res_r_q <= res_r_d;
            got_l_q <= got_l_d;
            got_r_q <= got_r_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            dac_l_q <= dac_l_d;
            dac_r_q <= dac_r_d;
        end
    end

endmodule

// File: tb/tb_stereo_sample_scheduler.sv
// Directed bench for stereo_sample_scheduler with a built-in latency-1 identity effect model.
module tb_stereo_sample_scheduler;

    localparam int unsigned Size      = 16;
    localparam int unsigned FxTimeout = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stereo_sample_scheduler_if #(.size(Size)) bus ();

    stereo_sample_scheduler #(
        .size      (Size),
        .FX_TIMEOUT(FxTimeout)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vec    = 0;
    int miscmp = 0;

    logic        auto_en  = 1'b0;
    logic        auto_vld = 1'b0;
    logic        auto_ch  = 1'b0;
    logic [15:0] auto_d   = '0;
    logic        man_vld  = 1'b0;
    logic        man_ch   = 1'b0;
    logic [15:0] man_d    = '0;

    // Identity effect chain: result appears the cycle after acceptance.
    always @(posedge clk) begin
        auto_vld <= bus.fx_in_vld & bus.fx_in_rdy;
        auto_d   <= bus.fx_in;
        auto_ch  <= bus.fx_in_ch;
    end

    assign bus.fx_out_vld = auto_en ? auto_vld : man_vld;
    assign bus.fx_out     = auto_en ? auto_d : man_d;
    assign bus.fx_out_ch  = auto_en ? auto_ch : man_ch;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.adc_vld   = 1'b0;
        bus.adc_l     = '0;
        bus.adc_r     = '0;
        bus.fx_in_rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        if (bus.adc_rdy !== 1'b1) begin miscmp++; $display("FAIL reset_adc_rdy got %h want 1", bus.adc_rdy); end vec++;
        if (bus.fx_in_vld !== 1'b0) begin miscmp++; $display("FAIL reset_fx_in_vld got %h want 0", bus.fx_in_vld); end vec++;
        if (bus.fx_in !== 16'h0000) begin miscmp++; $display("FAIL reset_fx_in got %h want 0000", bus.fx_in); end vec++;
        if (bus.fx_in_ch !== 1'b0) begin miscmp++; $display("FAIL reset_fx_in_ch got %h want 0", bus.fx_in_ch); end vec++;
        if (bus.dac_vld !== 1'b0) begin miscmp++; $display("FAIL reset_dac_vld got %h want 0", bus.dac_vld); end vec++;
        if (bus.err_timeout !== 1'b0) begin miscmp++; $display("FAIL reset_err got %h want 0", bus.err_timeout); end vec++;
        if (bus.dac_l !== 16'h8000) begin miscmp++; $display("FAIL reset_dac_l got %h want 8000", bus.dac_l); end vec++;
        if (bus.dac_r !== 16'h8000) begin miscmp++; $display("FAIL reset_dac_r got %h want 8000", bus.dac_r); end vec++;
        rst = 1'b0;
        tick();
        if (bus.adc_rdy !== 1'b1) begin miscmp++; $display("FAIL post_reset_adc_rdy got %h want 1", bus.adc_rdy); end vec++;
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        auto_en = 1'b0;
        bus.adc_vld = 1'b1; bus.adc_l = 16'h1111; bus.adc_r = 16'h2222;
        tick();                                   // SEND_L
        bus.adc_vld = 1'b0;
        tick();                                   // SEND_R
        man_vld = 1'b1; man_ch = 1'b0; man_d = 16'h0042;
        tick();                                   // WAIT, L captured
        man_vld = 1'b0;
        tick();                                   // still WAIT
        rst = 1'b1;
        tick();
        if (bus.adc_rdy !== 1'b1) begin miscmp++; $display("FAIL rst_wait_adc_rdy got %h want 1", bus.adc_rdy); end vec++;
        if (bus.fx_in_vld !== 1'b0) begin miscmp++; $display("FAIL rst_wait_fx_in_vld got %h want 0", bus.fx_in_vld); end vec++;
        rst = 1'b0;
        pulses = (bus.dac_vld === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.dac_vld === 1'b1) pulses++;
        end
        if (pulses != 0) begin miscmp++; $display("FAIL rst_wait_dac_pulses got %0d want 0", pulses); end vec++;
        if (bus.dac_l !== 16'h8000) begin miscmp++; $display("FAIL rst_wait_dac_l got %h want 8000", bus.dac_l); end vec++;
        if (bus.dac_r !== 16'h8000) begin miscmp++; $display("FAIL rst_wait_dac_r got %h want 8000", bus.dac_r); end vec++;
    endtask

    task automatic test_identity();
        int n;
        auto_en = 1'b1;
        bus.fx_in_rdy = 1'b1;
        bus.adc_vld = 1'b1; bus.adc_l = 16'h0000; bus.adc_r = 16'hFFFF;
        tick();                                   // handshake edge, now SEND_L
        bus.adc_vld = 1'b0;
        if (bus.fx_in_vld !== 1'b1) begin miscmp++; $display("FAIL id_fx_in_vld_l got %h want 1", bus.fx_in_vld); end vec++;
        if (bus.fx_in !== 16'h8000) begin miscmp++; $display("FAIL id_fx_in_l got %h want 8000", bus.fx_in); end vec++;
        if (bus.fx_in_ch !== 1'b0) begin miscmp++; $display("FAIL id_fx_in_ch_l got %h want 0", bus.fx_in_ch); end vec++;
        if (bus.adc_rdy !== 1'b0) begin miscmp++; $display("FAIL id_adc_rdy_busy got %h want 0", bus.adc_rdy); end vec++;
        tick();
        if (bus.fx_in !== 16'h7FFF) begin miscmp++; $display("FAIL id_fx_in_r got %h want 7fff", bus.fx_in); end vec++;
        if (bus.fx_in_ch !== 1'b1) begin miscmp++; $display("FAIL id_fx_in_ch_r got %h want 1", bus.fx_in_ch); end vec++;
        n = 2;
        while (bus.dac_vld !== 1'b1 && n < 20) begin tick(); n++; end
        if (n != 4) begin miscmp++; $display("FAIL id_latency got %0d want 4", n); end vec++;
        if (bus.dac_l !== 16'h0000) begin miscmp++; $display("FAIL id_dac_l got %h want 0000", bus.dac_l); end vec++;
        if (bus.dac_r !== 16'hFFFF) begin miscmp++; $display("FAIL id_dac_r got %h want ffff", bus.dac_r); end vec++;
        if (bus.err_timeout !== 1'b0) begin miscmp++; $display("FAIL id_err got %h want 0", bus.err_timeout); end vec++;
        tick();
        if (bus.dac_vld !== 1'b0) begin miscmp++; $display("FAIL id_dac_vld_pulse got %h want 0", bus.dac_vld); end vec++;
        if (bus.dac_l !== 16'h0000) begin miscmp++; $display("FAIL id_dac_l_hold got %h want 0000", bus.dac_l); end vec++;
    endtask

    task automatic test_out_of_order();
        auto_en = 1'b0;
        bus.adc_vld = 1'b1; bus.adc_l = 16'h8001; bus.adc_r = 16'h7FFF;
        tick();                                   // SEND_L
        bus.adc_vld = 1'b0;
        if (bus.fx_in !== 16'h0001) begin miscmp++; $display("FAIL ooo_fx_in_l got %h want 0001", bus.fx_in); end vec++;
        tick();                                   // SEND_R, R result arrives here
        if (bus.fx_in !== 16'hFFFF) begin miscmp++; $display("FAIL ooo_fx_in_r got %h want ffff", bus.fx_in); end vec++;
        man_vld = 1'b1; man_ch = 1'b1; man_d = 16'h0001;
        tick();                                   // WAIT, L result arrives here
        man_ch = 1'b0; man_d = 16'hFFFF;
        if (bus.dac_vld !== 1'b0) begin miscmp++; $display("FAIL ooo_early_dac got %h want 0", bus.dac_vld); end vec++;
        tick();
        man_vld = 1'b0;
        if (bus.dac_vld !== 1'b1) begin miscmp++; $display("FAIL ooo_dac_vld got %h want 1", bus.dac_vld); end vec++;
        if (bus.dac_l !== 16'h7FFF) begin miscmp++; $display("FAIL ooo_dac_l got %h want 7fff", bus.dac_l); end vec++;
        if (bus.dac_r !== 16'h8001) begin miscmp++; $display("FAIL ooo_dac_r got %h want 8001", bus.dac_r); end vec++;
        tick();
    endtask

    task automatic test_stall();
        auto_en = 1'b1;
        bus.fx_in_rdy = 1'b0;
        bus.adc_vld = 1'b1; bus.adc_l = 16'h1111; bus.adc_r = 16'h2222;
        tick();                                   // SEND_L
        bus.adc_l = 16'h3333; bus.adc_r = 16'h4444;   // competing frame held valid
        for (int i = 0; i < 3; i++) begin
            if (bus.fx_in_vld !== 1'b1) begin miscmp++; $display("FAIL stall_fx_in_vld[%0d] got %h want 1", i, bus.fx_in_vld); end vec++;
            if (bus.fx_in !== 16'h9111) begin miscmp++; $display("FAIL stall_fx_in[%0d] got %h want 9111", i, bus.fx_in); end vec++;
            if (bus.adc_rdy !== 1'b0) begin miscmp++; $display("FAIL stall_adc_rdy[%0d] got %h want 0", i, bus.adc_rdy); end vec++;
            tick();
        end
        bus.fx_in_rdy = 1'b1;
        bus.adc_vld = 1'b0;
        if (bus.fx_in !== 16'h9111) begin miscmp++; $display("FAIL stall_release_fx_in got %h want 9111", bus.fx_in); end vec++;
        tick();
        if (bus.fx_in !== 16'hA222) begin miscmp++; $display("FAIL stall_fx_in_r got %h want a222", bus.fx_in); end vec++;
        tick();
        tick();
        if (bus.dac_vld !== 1'b1) begin miscmp++; $display("FAIL stall_dac_vld got %h want 1", bus.dac_vld); end vec++;
        if (bus.dac_l !== 16'h1111) begin miscmp++; $display("FAIL stall_dac_l got %h want 1111", bus.dac_l); end vec++;
        if (bus.dac_r !== 16'h2222) begin miscmp++; $display("FAIL stall_dac_r got %h want 2222", bus.dac_r); end vec++;
        tick();
        tick();
        if (bus.fx_in_vld !== 1'b0) begin miscmp++; $display("FAIL stall_no_second_frame got %h want 0", bus.fx_in_vld); end vec++;
    endtask

    task automatic test_timeout();
        int n;
        auto_en = 1'b0;
        man_vld = 1'b0;
        bus.adc_vld = 1'b1; bus.adc_l = 16'h0000; bus.adc_r = 16'h0000;
        tick();                                   // SEND_L
        bus.adc_vld = 1'b0;
        tick();                                   // SEND_R
        man_vld = 1'b1; man_ch = 1'b0; man_d = 16'h1234;
        tick();                                   // first WAIT cycle
        man_vld = 1'b0;
        n = 0;
        while (bus.dac_vld !== 1'b1 && n < 30) begin n++; tick(); end
        if (n != 8) begin miscmp++; $display("FAIL to_wait_cycles got %0d want 8", n); end vec++;
        if (bus.err_timeout !== 1'b1) begin miscmp++; $display("FAIL to_err got %h want 1", bus.err_timeout); end vec++;
        if (bus.dac_l !== 16'h9234) begin miscmp++; $display("FAIL to_dac_l got %h want 9234", bus.dac_l); end vec++;
        if (bus.dac_r !== 16'h8000) begin miscmp++; $display("FAIL to_dac_r got %h want 8000", bus.dac_r); end vec++;
        tick();
        if (bus.err_timeout !== 1'b0) begin miscmp++; $display("FAIL to_err_pulse got %h want 0", bus.err_timeout); end vec++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] tl [4];
        logic [15:0] tr [4];
        int k, m, last, pulses;
        tl = '{16'h0001, 16'h8000, 16'h1357, 16'hABCD};
        tr = '{16'hFFFE, 16'h7FFF, 16'h2468, 16'h0F0F};
        auto_en = 1'b1;
        bus.fx_in_rdy = 1'b1;
        k = 0; m = 0; last = 0; pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.dac_vld === 1'b1) begin
                pulses++;
                if (m < 4) begin
                    if (bus.dac_l !== tl[m]) begin miscmp++; $display("FAIL b2b_dac_l[%0d] got %h want %h", m, bus.dac_l, tl[m]); end vec++;
                    if (bus.dac_r !== tr[m]) begin miscmp++; $display("FAIL b2b_dac_r[%0d] got %h want %h", m, bus.dac_r, tr[m]); end vec++;
                    if (m > 0) begin
                        if (c - last != 5) begin miscmp++; $display("FAIL b2b_spacing[%0d] got %0d want 5", m, c - last); end vec++;
                    end
                end
                last = c;
                m++;
            end
            if (bus.adc_rdy === 1'b1) begin
                if (k < 4) begin
                    bus.adc_vld = 1'b1; bus.adc_l = tl[k]; bus.adc_r = tr[k];
                    k++;
                end else begin
                    bus.adc_vld = 1'b0;
                end
            end
            tick();
        end
        bus.adc_vld = 1'b0;
        if (pulses != 4) begin miscmp++; $display("FAIL b2b_frame_count got %0d want 4", pulses); end vec++;
    endtask

    initial begin
        test_reset();
        test_reset_in_wait();
        test_identity();
        test_out_of_order();
        test_stall();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
